// File: rtl/reg_file_pkg.sv
// Shared constants and types for the reg_file register bank.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned NUM_REGS   = 1 << DEF_ADDR_W;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// One registered read port: select mux, optional write-through, output register.
// Optional feature: REG_FILE_BYPASS_EN adds same-cycle write-through.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_sel,
  input  logic [DATA_W-1:0] i_regs [1<<ADDR_W],
`ifdef REG_FILE_BYPASS_EN
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_sel,
  input  logic [DATA_W-1:0] i_wr_data,
`endif
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] r_data;

  // Select the addressed register, overridden by the in-flight write when bypass is built.
  always_comb begin
    w_rd_data = i_regs[i_sel];
`ifdef REG_FILE_BYPASS_EN
    if (i_wr_en && (i_wr_sel == i_sel)) begin
      w_rd_data = i_wr_data;
    end
`endif
  end

  // Output register: cleared by reset, loaded only on an enabled read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
    end else if (i_rd_en) begin
      r_data <= w_rd_data;
    end
  end

  assign o_data = r_data;

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// Register file: one write port, two independent registered read ports.
// Optional feature: define REG_FILE_BYPASS_EN for write-through on same-address read.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              WR,
  input  logic              RD,
  input  logic [DATA_W-1:0] Ip1,
  input  logic [ADDR_W-1:0] sel_i1,
  input  logic [ADDR_W-1:0] sel_o1,
  input  logic [ADDR_W-1:0] sel_o2,
  output logic [DATA_W-1:0] Op1,
  output logic [DATA_W-1:0] Op2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_wr_en;
  logic              w_rd_en;

  assign w_wr_en = EN & WR;
  assign w_rd_en = EN & RD;

  // Storage array: synchronous clear, single write port gated by EN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[sel_i1] <= Ip1;
    end
  end

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (w_rd_en),
    .i_sel     (sel_o1),
    .i_regs    (r_regs),
`ifdef REG_FILE_BYPASS_EN
    .i_wr_en   (w_wr_en),
    .i_wr_sel  (sel_i1),
    .i_wr_data (Ip1),
`endif
    .o_data    (Op1)
  );

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (w_rd_en),
    .i_sel     (sel_o2),
    .i_regs    (r_regs),
`ifdef REG_FILE_BYPASS_EN
    .i_wr_en   (w_wr_en),
    .i_wr_sel  (sel_i1),
    .i_wr_data (Ip1),
`endif
    .o_data    (Op2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        EN;
  logic        WR;
  logic        RD;
  logic [31:0] Ip1;
  logic [3:0]  sel_i1;
  logic [3:0]  sel_o1;
  logic [3:0]  sel_o2;
  logic [31:0] Op1;
  logic [31:0] Op2;

  int unsigned n_checks;
  int unsigned n_errors;

  reg_file dut (
    .clk    (clk),
    .rst    (rst),
    .EN     (EN),
    .WR     (WR),
    .RD     (RD),
    .Ip1    (Ip1),
    .sel_i1 (sel_i1),
    .sel_o1 (sel_o1),
    .sel_o2 (sel_o2),
    .Op1    (Op1),
    .Op2    (Op2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_same_cycle;

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef REG_FILE_BYPASS_EN
    exp_same_cycle = 32'hFFFF0000;
`else
    exp_same_cycle = 32'h01234567;
`endif

    rst = 1'b0; EN = 1'b1; WR = 1'b1; RD = 1'b1;
    Ip1 = 32'hCAFEF00D; sel_i1 = 4'd3; sel_o1 = 4'd3; sel_o2 = 4'd3;
    repeat (5) tick();
    check("reset_op1", Op1, 32'h0);
    check("reset_op2", Op2, 32'h0);

    // Release reset with a read of 0 and 15.
    rst = 1'b1; WR = 1'b0; RD = 1'b1; sel_o1 = 4'd0; sel_o2 = 4'd15;
    tick();
    check("post_reset_op1", Op1, 32'h0);
    check("post_reset_op2", Op2, 32'h0);
    sel_o1 = 4'd3;
    tick();
    check("reset_cleared_reg3", Op1, 32'h0);

    // Two writes then a dual read.
    RD = 1'b0; WR = 1'b1; sel_i1 = 4'd0; Ip1 = 32'hABCDEFAB;
    tick();
    sel_i1 = 4'd1; Ip1 = 32'h01234567;
    tick();
    check("rd0_hold_op1", Op1, 32'h0);
    WR = 1'b0; RD = 1'b1; sel_o1 = 4'd0; sel_o2 = 4'd1;
    tick();
    check("read_addr0", Op1, 32'hABCDEFAB);
    check("read_addr1", Op2, 32'h01234567);

    // EN=0: no write, no output change.
    EN = 1'b0; WR = 1'b1; RD = 1'b1; Ip1 = 32'hDEADBEEF; sel_i1 = 4'd0;
    sel_o1 = 4'd1; sel_o2 = 4'd0;
    tick();
    check("en0_hold_op1", Op1, 32'hABCDEFAB);
    check("en0_hold_op2", Op2, 32'h01234567);
    tick();
    check("en0_hold_op1_b", Op1, 32'hABCDEFAB);
    EN = 1'b1; WR = 1'b0; sel_o1 = 4'd0; sel_o2 = 4'd0;
    tick();
    check("en0_no_write", Op1, 32'hABCDEFAB);
    check("en0_no_write_p2", Op2, 32'hABCDEFAB);

    // RD=0 with EN=1 holds outputs.
    RD = 1'b0; sel_o1 = 4'd1; sel_o2 = 4'd1;
    tick();
    check("rd0_hold_op1_b", Op1, 32'hABCDEFAB);

    // Top address, both ports selecting it.
    WR = 1'b1; sel_i1 = 4'd15; Ip1 = 32'h5A5A5A5A;
    tick();
    WR = 1'b0; RD = 1'b1; sel_o1 = 4'd15; sel_o2 = 4'd15;
    tick();
    check("top_addr_op1", Op1, 32'h5A5A5A5A);
    check("top_addr_op2", Op2, 32'h5A5A5A5A);

    // Same-cycle write and read of address 1.
    WR = 1'b1; RD = 1'b1; sel_i1 = 4'd1; Ip1 = 32'hFFFF0000;
    sel_o1 = 4'd1; sel_o2 = 4'd15;
    tick();
    check("wr_rd_same_op1", Op1, exp_same_cycle);
    check("wr_rd_other_op2", Op2, 32'h5A5A5A5A);
    WR = 1'b0;
    tick();
    check("wr_rd_next_op1", Op1, 32'hFFFF0000);

    // Reset colliding with a write.
    rst = 1'b0; WR = 1'b1; RD = 1'b1; sel_i1 = 4'd2; Ip1 = 32'h11111111;
    tick();
    check("rst_mid_op1", Op1, 32'h0);
    check("rst_mid_op2", Op2, 32'h0);
    rst = 1'b1; WR = 1'b0; RD = 1'b1; sel_o1 = 4'd0; sel_o2 = 4'd1;
    tick();
    check("rst_clr_addr0", Op1, 32'h0);
    check("rst_clr_addr1", Op2, 32'h0);
    sel_o1 = 4'd2; sel_o2 = 4'd15;
    tick();
    check("rst_clr_addr2", Op1, 32'h0);
    check("rst_clr_addr15", Op2, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter DATA_W, default 32, SHALL set the register and port data width.
REQ-003 Parameter ADDR_W, default 4, SHALL set the select width; the depth SHALL be 2**ADDR_W (16 registers).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 EN  input  1  global enable; when 0, no register or output SHALL change.
REQ-007 WR  input  1  write strobe.
REQ-008 RD  input  1  read strobe.
REQ-009 Ip1  input  DATA_W  write data.
REQ-010 sel_i1  input  ADDR_W  write address.
REQ-011 sel_o1  input  ADDR_W  read address, port 1.
REQ-012 sel_o2  input  ADDR_W  read address, port 2.
REQ-013 Op1  output  DATA_W  registered read data, port 1.
REQ-014 Op2  output  DATA_W  registered read data, port 2.

Function
REQ-015 On a rising clk edge with rst=1, EN=1 and WR=1, the block SHALL write Ip1 into register sel_i1.
REQ-016 On a rising clk edge with rst=1, EN=1 and RD=1, the block SHALL load Op1 with register[sel_o1] and Op2 with register[sel_o2]; read latency SHALL be one clock.
REQ-017 With RD=0 or EN=0, Op1 and Op2 SHALL hold their previous values.
REQ-018 With WR=0 or EN=0, the register contents SHALL be unchanged.
REQ-019 WR and RD asserted together SHALL perform both operations in the same cycle.
REQ-020 Both read ports SHALL be independent, and the two ports MAY select the same address, with both returning identical data.
REQ-021 All addresses 0..2**ADDR_W-1, including 0 and the top address, SHALL be ordinary writable registers with no hardwired value.
REQ-022 A same-cycle read of the address being written SHALL return the old contents, unless the bypass macro in REQ-026 is defined.

Reset
REQ-023 With rst=0 at a rising clk edge, all registers and both Op1 and Op2 SHALL become 0, regardless of EN, WR and RD.
REQ-024 Reset SHALL take priority over any simultaneous write or read, including a reset asserted mid-sequence.
REQ-025 Outputs SHALL read 0 on the first clk edge after reset until an enabled read occurs.

Configuration
REQ-026 When macro REG_FILE_BYPASS_EN is defined, a read port whose select equals sel_i1 during an enabled write SHALL return Ip1 in that same cycle, for write-through behaviour.
REQ-027 When REG_FILE_BYPASS_EN is not defined, no bypass logic SHALL be built and REQ-022 old-data behaviour SHALL apply.

Structure
REQ-028 A package reg_file_pkg SHALL hold DATA_W and ADDR_W defaults, the derived NUM_REGS constant, and the data_t and addr_t typedefs.
REQ-029 The read path SHALL be one sub-module, reg_file_rd_port (mux, optional bypass and output register), instantiated twice.

Verification
REQ-030 Hold rst=0 for 5 cycles, then release with RD=1, EN=1, sel_o1=0, sel_o2=15 -> Op1=0x00000000 and Op2=0x00000000.
REQ-031 EN=1, WR=1, write 0xABCDEFAB to address 0, then 0x01234567 to address 1; then WR=0, RD=1, sel_o1=0, sel_o2=1 -> one clock later Op1=0xABCDEFAB and Op2=0x01234567.
REQ-032 EN=0, WR=1, Ip1=0xDEADBEEF to address 0, then an enabled read of address 0 -> Op1=0xABCDEFAB, and Op1/Op2 do not change while EN=0.
REQ-033 Write 0x5A5A5A5A to address 15, read it with sel_o1=sel_o2=15 -> Op1=Op2=0x5A5A5A5A.
REQ-034 WR=1 and RD=1 in the same cycle to address 1 with Ip1=0xFFFF0000 -> Op1=0x01234567 without the macro, 0xFFFF0000 with REG_FILE_BYPASS_EN; the next read returns 0xFFFF0000 in both cases.
REQ-035 Assert rst=0 in the same cycle as a write of 0x11111111 to address 2 -> a subsequent read of addresses 0, 1 and 2 returns 0x00000000.
